// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/status inputs from the ID/EX/MEM stages and the
// stall, bubble, flush and redirect controls going back to them.
// Purely a wiring container; timing is defined by pipe_ctrl.
interface pipe_ctrl_if;
    logic        id_reg1_read;
    logic        id_reg2_read;
    logic [4:0]  id_reg1_addr;
    logic [4:0]  id_reg2_addr;
    logic        ex_is_load;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic        ex_mc_req;
    logic        mc_done;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        mem_stall_req;

    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        bubble_id_ex;
    logic        bubble_ex_mem;
    logic        flush_if_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mc_start;
    logic        mc_error;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    // Controller side
    modport slave (
        input  id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
               ex_is_load, ex_wd, ex_wreg, ex_mc_req, mc_done,
               ex_branch_taken, ex_branch_target, mem_stall_req,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               bubble_id_ex, bubble_ex_mem, flush_if_id, redirect_valid,
               redirect_pc, mc_start, mc_error, state, stall_cycles
    );

    // Pipeline side
    modport master (
        output id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
               ex_is_load, ex_wd, ex_wreg, ex_mc_req, mc_done,
               ex_branch_taken, ex_branch_target, mem_stall_req,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               bubble_id_ex, bubble_ex_mem, flush_if_id, redirect_valid,
               redirect_pc, mc_start, mc_error, state, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect, multi-cycle op wait with timeout.
// Latency: stall/bubble/flush/redirect are combinational in the same cycle; FSM, counters are registered.
// Backpressure: mem_stall_req holds every pipeline register and freezes the FSM and wait counter.
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave pc
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1
    } state_e;

    localparam int unsigned CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MC_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;

    logic        in_wait;
    logic        load_use;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        bubble_id_ex, bubble_ex_mem, flush_if_id, redirect_valid, mc_start;
    logic [31:0] redirect_pc;

    // Encodings other than MC_WAIT (including the unused ones) behave as RUN.
    assign in_wait = (state_q == MC_WAIT);

    // Consumer in ID reads the register the load in EX will write; r0 never hazards.
    assign load_use = pc.ex_is_load && pc.ex_wreg && (pc.ex_wd != 5'd0) &&
                      ((pc.id_reg1_read && (pc.id_reg1_addr == pc.ex_wd)) ||
                       (pc.id_reg2_read && (pc.id_reg2_addr == pc.ex_wd)));

    // Priority decode: MEM backpressure > multi-cycle wait > branch > multi-cycle issue > load-use.
    always_comb begin
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        bubble_id_ex   = 1'b0;
        bubble_ex_mem  = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mc_start       = 1'b0;
        if (in_wait) state_d = MC_WAIT;
        else         state_d = RUN;
        cnt_d          = cnt_q;
        err_d          = err_q;
        if (!rst) begin
            if (pc.mem_stall_req) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
            end else if (in_wait) begin
                if (pc.mc_done) begin
                    // Result ready (also wins over a same-cycle timeout): let it advance.
                    state_d = RUN;
                end else begin
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    stall_id_ex   = 1'b1;
                    bubble_ex_mem = 1'b1;
                    if (cnt_q == LAST) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end else if (pc.ex_branch_taken) begin
                flush_if_id    = 1'b1;
                bubble_id_ex   = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = pc.ex_branch_target;
            end else if (pc.ex_mc_req) begin
                mc_start      = 1'b1;
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                bubble_ex_mem = 1'b1;
                state_d       = MC_WAIT;
                cnt_d         = '0;
            end else if (load_use) begin
                // The load moves on to MEM next cycle, so this yields exactly one bubble.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Saturating count of cycles in which fetch was held.
    assign stall_cycles_d = (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                            stall_cycles_q + 32'd1 : stall_cycles_q;

    // All controller state; reset aborts any wait without flagging an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pc.stall_pc       = stall_pc;
    assign pc.stall_if_id    = stall_if_id;
    assign pc.stall_id_ex    = stall_id_ex;
    assign pc.stall_ex_mem   = stall_ex_mem;
    assign pc.bubble_id_ex   = bubble_id_ex;
    assign pc.bubble_ex_mem  = bubble_ex_mem;
    assign pc.flush_if_id    = flush_if_id;
    assign pc.redirect_valid = redirect_valid;
    assign pc.redirect_pc    = redirect_pc;
    assign pc.mc_start       = mc_start;
    assign pc.mc_error       = err_q;
    assign pc.state          = state_q;
    assign pc.stall_cycles   = stall_cycles_q;
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MC_TIMEOUT, default 32, max MC_WAIT cycles before abort.
REQ-002 Port: clk  in  1  single clock; all state on posedge.
REQ-003 Port: rst  in  1  synchronous, active-high reset (RstEnable = 1).
REQ-004 Port: id_reg1_read / id_reg2_read  in  1 each  ID source operand used.
REQ-005 Port: id_reg1_addr / id_reg2_addr  in  5 each  ID source register addresses.
REQ-006 Port: ex_is_load  in  1  instruction in EX is a load.
REQ-007 Port: ex_wd  in  5  EX destination register; ex_wreg  in  1  EX write enable.
REQ-008 Port: ex_mc_req  in  1  EX holds a multi-cycle op (div/mul); mc_done  in  1  multi-cycle unit result ready.
REQ-009 Port: ex_branch_taken  in  1; ex_branch_target  in  32  resolved branch in EX.
REQ-010 Port: mem_stall_req  in  1  MEM stage not ready.
REQ-011 Port: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold that register.
REQ-012 Port: bubble_id_ex  out  1  load NOP (I-type op, NOP funct3, wreg off) into ID/EX; bubble_ex_mem  out  1  load NOP into EX/MEM.
REQ-013 Port: flush_if_id  out  1  squash IF/ID; redirect_valid  out  1; redirect_pc  out  32.
REQ-014 Port: mc_start  out  1  one-cycle start pulse to multi-cycle unit.
REQ-015 Port: mc_error  out  1  sticky timeout flag; state  out  2  FSM state; stall_cycles  out  32  perf counter.

Function
REQ-016 FSM states SHALL be RUN=0, MC_WAIT=1, with encodings 2/3 unused and treated as RUN.
REQ-017 State, wait counter, mc_error, stall_cycles SHALL be registered; all other outputs combinational from state and inputs.
REQ-018 Priority SHALL be: mem_stall_req > MC_WAIT > branch taken > mc_req issue > load-use.
REQ-019 mem_stall_req=1 SHALL assert all four stall_* outputs, deassert bubbles, flush, redirect, mc_start, and freeze state and wait counter.
REQ-020 Load-use hazard = ex_is_load & ex_wreg & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)).
REQ-021 In RUN with load-use and no higher priority: stall_pc=stall_if_id=1, bubble_id_ex=1, same cycle; exactly one bubble per load.
REQ-022 In RUN with ex_branch_taken: flush_if_id=1, bubble_id_ex=1, redirect_valid=1, redirect_pc=ex_branch_target for one cycle; load-use ignored that cycle.
REQ-023 In RUN with ex_mc_req and no branch: mc_start=1 for one cycle, stall_pc/if_id/id_ex=1, bubble_ex_mem=1, next state MC_WAIT, counter cleared.
REQ-024 In MC_WAIT without mc_done: stall_pc/if_id/id_ex=1, bubble_ex_mem=1, counter increments by 1.
REQ-025 In MC_WAIT with mc_done: all stalls and bubbles deasserted that cycle (result advances), next state RUN.
REQ-026 mc_done and counter==MC_TIMEOUT-1 in same cycle SHALL be treated as done; no error.
REQ-027 Counter reaching MC_TIMEOUT-1 without mc_done SHALL set mc_error, bubble_ex_mem=1, return to RUN next cycle.
REQ-028 mc_done outside MC_WAIT SHALL be ignored; mc_start SHALL never assert in MC_WAIT.
REQ-029 stall_cycles SHALL increment each cycle stall_pc=1, saturating at 0xFFFF_FFFF.
REQ-030 redirect_pc SHALL be 0 whenever redirect_valid=0.

Reset
REQ-031 rst=1 at posedge SHALL set state=RUN, counter=0, mc_error=0, stall_cycles=0.
REQ-032 While rst=1 all combinational outputs SHALL be 0 regardless of inputs.
REQ-033 rst during MC_WAIT SHALL abort the wait without mc_error; a late mc_done is ignored.
REQ-034 mc_error SHALL clear only on reset.

Verification
REQ-035 Load-use: ex_is_load=1, ex_wd=5, ex_wreg=1, id_reg2_read=1, id_reg2_addr=5 -> one cycle stall_pc=stall_if_id=bubble_id_ex=1; ex_wd=0 -> no stall.
REQ-036 Branch+load-use same cycle: ex_branch_taken=1, target 0x0000_1000 -> flush_if_id=1, redirect_valid=1, redirect_pc=0x1000, stall_pc=0.
REQ-037 Divide: ex_mc_req=1, mc_done after 10 MC_WAIT cycles -> mc_start one pulse, 11 stalled cycles, state back to 0, stall_cycles=11.
REQ-038 Timeout: MC_TIMEOUT=4, no mc_done -> mc_error=1 after 4 MC_WAIT cycles, state RUN, mc_error stays until rst.
REQ-039 mem_stall_req=1 for 3 cycles during MC_WAIT with mc_done=1 -> all stalls held, state and counter frozen, completion after release.
REQ-040 rst=1 mid MC_WAIT -> next cycle state=0, stall_cycles=0, all outputs 0.
